// File: rtl/gp_capture_if.sv
// Bus-side signal bundle for the input-capture timer.
// The prescale input exists only when GP_CAPTURE_PRESCALE_EN is defined.
`timescale 1ns/1ps

interface gp_capture_if #(
    parameter int WIDTH = 16
);
    logic             cap_in;
    logic             en;
    logic [1:0]       edge_sel;
    logic             rst_int_n;
`ifdef GP_CAPTURE_PRESCALE_EN
    logic [7:0]       prescale;
`endif
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             int_n;

    modport master (
        output cap_in,
        output en,
        output edge_sel,
        output rst_int_n,
`ifdef GP_CAPTURE_PRESCALE_EN
        output prescale,
`endif
        input  value,
        input  count,
        input  ovf,
        input  int_n
    );

    modport slave (
        input  cap_in,
        input  en,
        input  edge_sel,
        input  rst_int_n,
`ifdef GP_CAPTURE_PRESCALE_EN
        input  prescale,
`endif
        output value,
        output count,
        output ovf,
        output int_n
    );
endinterface

// File: rtl/gp_capture.sv
// Input-capture timer: measures tclk ticks between qualifying cap_in edges.
// Optional tick divider is enabled by defining GP_CAPTURE_PRESCALE_EN.
`timescale 1ns/1ps

module gp_capture #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         tclk,
    input  logic         rst_n,
    gp_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       value_q, value_d;
    logic                   ovf_q, ovf_d;
    logic                   int_n_q, int_n_d;

    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;
    logic                   tick;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.cap_in};
        prev_d = sync_out;
    end

    always_comb begin
        edge_det = rise;
        case (bus.edge_sel)
            2'b01:   edge_det = fall;
            2'b10:   edge_det = rise | fall;
            default: edge_det = rise;
        endcase
    end

`ifdef GP_CAPTURE_PRESCALE_EN
    // The divisor is latched on every restart so a new prescale never splits a tick.
    logic [7:0] divcnt_q, divcnt_d;
    logic [7:0] ps_q, ps_d;
    logic       restart;

    assign tick = (divcnt_q == ps_q);

    always_comb begin
        restart  = !bus.en || (state_q != MEASURE) || edge_det || tick;
        divcnt_d = restart ? 8'd0 : divcnt_q + 8'd1;
        ps_d     = restart ? bus.prescale : ps_q;
    end

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            divcnt_q <= 8'd0;
            ps_q     <= 8'd0;
        end else begin
            divcnt_q <= divcnt_d;
            ps_q     <= ps_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A capture or overflow in the same cycle as a clear overrides the clear.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        int_n_d = int_n_q;

        if (!bus.rst_int_n) begin
            int_n_d = 1'b1;
            ovf_d   = 1'b0;
        end

        if (!bus.en) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    state_d = ARMED;
                end
                ARMED: begin
                    count_d = '0;
                    if (edge_det) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        value_d = (count_q == MAX_COUNT) ? MAX_COUNT
                                                         : count_q + WIDTH'(1);
                        count_d = '0;
                        int_n_d = 1'b0;
                    end else if (tick) begin
                        if (count_q == MAX_COUNT) begin
                            ovf_d   = 1'b1;
                            int_n_d = 1'b0;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
            value_q <= '0;
            ovf_q   <= 1'b0;
            int_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
            int_n_q <= int_n_d;
        end
    end

    assign bus.value = value_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.int_n = int_n_q;

endmodule

// File: tb/tb_gp_capture.sv
// Self-checking bench for gp_capture: directed scenarios plus randomized cap_in
// traffic, checked every cycle against an interval-arithmetic reference model.
`timescale 1ns/1ps

module tb_gp_capture;

    localparam int W    = 12;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic tclk  = 1'b0;
    logic rst_n = 1'b0;

    gp_capture_if #(.WIDTH(W)) bus ();

    gp_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .tclk  (tclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 tclk = ~tclk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 armed, 2 measuring; m_e counts non-edge
    // cycles since measuring started, and count/value follow from it arithmetically.
    int m_mode  = 0;
    int m_e     = 0;
    int m_value = 0;
    bit m_ovf   = 1'b0;
    bit m_int_n = 1'b1;
    bit hist [S+1];
    bit m_so, m_pv, m_qe;
    int m_p, m_v;

    function automatic int exp_count();
        int c;
        if (m_mode != 2) return 0;
        c = m_e / (m_p + 1);
        return (c > MAXV) ? MAXV : c;
    endfunction

    always @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = 0;
            m_e     = 0;
            m_value = 0;
            m_ovf   = 1'b0;
            m_int_n = 1'b1;
            for (int i = 0; i <= S; i++) hist[i] = 1'b0;
        end else begin
`ifdef GP_CAPTURE_PRESCALE_EN
            m_p = int'(bus.prescale);
`else
            m_p = 0;
`endif
            m_so = hist[S-1];
            m_pv = hist[S];
            case (bus.edge_sel)
                2'b01:   m_qe = !m_so && m_pv;
                2'b10:   m_qe = m_so != m_pv;
                default: m_qe = m_so && !m_pv;
            endcase
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.cap_in;

            if (!bus.rst_int_n) begin
                m_int_n = 1'b1;
                m_ovf   = 1'b0;
            end
            if (!bus.en) begin
                m_mode = 0;
                m_e    = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_qe) begin
                    m_mode = 2;
                    m_e    = 0;
                end
            end else begin
                if (m_qe) begin
                    m_v     = m_e / (m_p + 1) + 1;
                    m_value = (m_v > MAXV) ? MAXV : m_v;
                    m_int_n = 1'b0;
                    m_e     = 0;
                end else begin
                    m_e = m_e + 1;
                    if ((m_e % (m_p + 1) == 0) && (m_e / (m_p + 1) > MAXV)) begin
                        m_ovf   = 1'b1;
                        m_int_n = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(posedge tclk) begin
        #1;
        tests++;
        if (int'(bus.value) != m_value || int'(bus.count) != exp_count() ||
            bus.ovf !== m_ovf || bus.int_n !== m_int_n) begin
            fails++;
            $display("[TB] FAIL cycle_check t=%0t: got value=%0d count=%0d ovf=%b int_n=%b, exp value=%0d count=%0d ovf=%b int_n=%b",
                     $time, bus.value, bus.count, bus.ovf, bus.int_n,
                     m_value, exp_count(), m_ovf, m_int_n);
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge tclk);
    endtask

    task automatic apply_stimulus(input logic cap, input logic en, input logic [1:0] sel,
                                  input logic rint);
        bus.cap_in    = cap;
        bus.en        = en;
        bus.edge_sel  = sel;
        bus.rst_int_n = rint;
    endtask

    initial begin
        int hold;
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1);
`ifdef GP_CAPTURE_PRESCALE_EN
        bus.prescale = 8'd0;
`endif

        // Reset with cap_in toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge tclk);
            bus.cap_in = ~bus.cap_in;
        end
        @(negedge tclk);
        check_output("reset_int_n", int'(bus.int_n), 1);
        check_output("reset_value", int'(bus.value), 0);
        check_output("reset_count", int'(bus.count), 0);
        check_output("reset_ovf", int'(bus.ovf), 0);
        bus.cap_in = 1'b0;
        rst_n = 1'b1;
        wait_cycles(S + 2);

        // Rising edges 100 apart.
        bus.en = 1'b1;
        wait_cycles(5);
        for (int k = 0; k < 4; k++) begin
            bus.cap_in = 1'b1;
            wait_cycles(S + 3);
            if (k == 0) begin
                check_output("first_edge_no_int", int'(bus.int_n), 1);
            end else begin
                check_output("period100_value", int'(bus.value), 100);
                check_output("period100_int_n", int'(bus.int_n), 0);
            end
            wait_cycles(50 - (S + 3));
            bus.cap_in = 1'b0;
            wait_cycles(50);
        end

        // Interrupt clear, then clear colliding with a capture.
        bus.rst_int_n = 1'b0;
        wait_cycles(1);
        bus.rst_int_n = 1'b1;
        check_output("clear_int_n", int'(bus.int_n), 1);
        bus.cap_in = 1'b1;
        wait_cycles(S);
        bus.rst_int_n = 1'b0;
        wait_cycles(1);
        bus.rst_int_n = 1'b1;
        check_output("clear_vs_capture_int_n", int'(bus.int_n), 0);
        wait_cycles(20);

        // Both edges, high 30 / low 70.
        bus.edge_sel = 2'b10;
        bus.cap_in   = 1'b0;
        wait_cycles(70);
        for (int k = 0; k < 3; k++) begin
            bus.cap_in = 1'b1;
            wait_cycles(S + 3);
            check_output("both_low70", int'(bus.value), 70);
            wait_cycles(30 - (S + 3));
            bus.cap_in = 1'b0;
            wait_cycles(S + 3);
            check_output("both_high30", int'(bus.value), 30);
            wait_cycles(70 - (S + 3));
        end

        // Overflow: measuring with no further edge.
        bus.edge_sel = 2'b00;
        bus.cap_in   = 1'b1;
        wait_cycles(MAXV + 20);
        check_output("ovf_count", int'(bus.count), MAXV);
        check_output("ovf_flag", int'(bus.ovf), 1);
        check_output("ovf_int_n", int'(bus.int_n), 0);
        bus.cap_in = 1'b0;
        wait_cycles(2);
        bus.cap_in = 1'b1;
        wait_cycles(S + 3);
        check_output("sat_value", int'(bus.value), MAXV);
        check_output("ovf_sticky", int'(bus.ovf), 1);

        // Enable drop mid-measure and re-arm.
        bus.rst_int_n = 1'b0;
        wait_cycles(1);
        bus.rst_int_n = 1'b1;
        wait_cycles(10);
        bus.en = 1'b0;
        wait_cycles(2);
        check_output("en_drop_count", int'(bus.count), 0);
        check_output("en_drop_value_kept", int'(bus.value), MAXV);
        bus.en = 1'b1;
        wait_cycles(3);
        bus.cap_in = 1'b0;
        wait_cycles(3);
        bus.cap_in = 1'b1;
        wait_cycles(S + 3);
        check_output("rearm_no_int", int'(bus.int_n), 1);
        wait_cycles(20);
        bus.cap_in = 1'b0;
        wait_cycles(5);
        bus.cap_in = 1'b1;
        wait_cycles(S + 3);
        check_output("rearm_interval", int'(bus.value), (S + 3) + 20 + 5);

        // Randomized traffic with clears, enable drops, edge-select changes and one reset.
        for (int it = 0; it < 160; it++) begin
            if (it == 80) begin
                @(negedge tclk);
                #2 rst_n = 1'b0;
                bus.en = 1'b0;
                wait_cycles(3);
                rst_n = 1'b1;
                wait_cycles(S + 2);
                bus.en = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) bus.edge_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            if (!bus.en && $urandom_range(0, 1) == 0) bus.en = 1'b1;
            bus.cap_in = ~bus.cap_in;
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                bus.rst_int_n = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
                wait_cycles(1);
            end
            bus.rst_int_n = 1'b1;
        end

`ifdef GP_CAPTURE_PRESCALE_EN
        // Divider: prescale 3, rising edges 8 apart.
        bus.en       = 1'b0;
        bus.edge_sel = 2'b00;
        bus.cap_in   = 1'b0;
        bus.prescale = 8'd3;
        wait_cycles(S + 2);
        bus.en = 1'b1;
        wait_cycles(3);
        for (int k = 0; k < 3; k++) begin
            bus.cap_in = 1'b1;
            wait_cycles(4);
            bus.cap_in = 1'b0;
            wait_cycles(4);
        end
        bus.cap_in = 1'b1;
        wait_cycles(S + 3);
        check_output("prescale3_value", int'(bus.value), 2);
`endif

        wait_cycles(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
